// File: rtl/rv_multicore_mc_pkg.sv
// Shared definitions for the rv_multicore_mc core: opcodes, funct codes, ALU ops, FSM states, decoder.
// Defining RVMC_BRANCH_EN makes the decoder accept BEQ/BNE; otherwise B-type opcodes are illegal.
package rv_multicore_mc_pkg;

  localparam logic [6:0] R_TYPE = 7'b0110011;
  localparam logic [6:0] I_TYPE = 7'b0010011;
  localparam logic [6:0] B_TYPE = 7'b1100011;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SR      = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;
  localparam logic [2:0] F3_BEQ     = 3'b000;
  localparam logic [2:0] F3_BNE     = 3'b001;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_op_e;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    DECODE = 2'd1,
    EXEC   = 2'd2,
    WB     = 2'd3
  } state_e;

  typedef struct packed {
    logic    legal;
    logic    wr;
    logic    use_imm;
    logic    branch;
    logic    br_ne;
    alu_op_e op;
  } dec_t;

  function automatic dec_t decode_instr(input logic [6:0] opc, input logic [2:0] f3,
                                        input logic [6:0] f7);
    dec_t d;
    d = '{legal: 1'b0, wr: 1'b0, use_imm: 1'b0, branch: 1'b0, br_ne: 1'b0, op: ALU_ADD};
    case (opc)
      R_TYPE: begin
        d.legal = 1'b1;
        d.wr    = 1'b1;
        case (f3)
          F3_ADD_SUB: begin
            if (f7 == F7_BASE) d.op = ALU_ADD;
            else if (f7 == F7_ALT) d.op = ALU_SUB;
            else d.legal = 1'b0;
          end
          F3_SR: begin
            if (f7 == F7_BASE) d.op = ALU_SRL;
            else if (f7 == F7_ALT) d.op = ALU_SRA;
            else d.legal = 1'b0;
          end
          F3_SLL:  d.op = ALU_SLL;
          F3_SLT:  d.op = ALU_SLT;
          F3_SLTU: d.op = ALU_SLTU;
          F3_XOR:  d.op = ALU_XOR;
          F3_OR:   d.op = ALU_OR;
          F3_AND:  d.op = ALU_AND;
          default: d.legal = 1'b0;
        endcase
        // Apart from SUB/SRA, every R-type form needs an all-zero funct7.
        if ((f3 != F3_ADD_SUB) && (f3 != F3_SR) && (f7 != F7_BASE)) d.legal = 1'b0;
        else d.legal = d.legal;
      end
      I_TYPE: begin
        d.legal   = 1'b1;
        d.wr      = 1'b1;
        d.use_imm = 1'b1;
        case (f3)
          F3_ADD_SUB: d.op = ALU_ADD;
          F3_SLT:     d.op = ALU_SLT;
          F3_SLTU:    d.op = ALU_SLTU;
          F3_XOR:     d.op = ALU_XOR;
          F3_OR:      d.op = ALU_OR;
          F3_AND:     d.op = ALU_AND;
          F3_SLL: begin
            d.op = ALU_SLL;
            if (f7 != F7_BASE) d.legal = 1'b0;
            else d.legal = 1'b1;
          end
          F3_SR: begin
            if (f7 == F7_BASE) d.op = ALU_SRL;
            else if (f7 == F7_ALT) d.op = ALU_SRA;
            else d.legal = 1'b0;
          end
          default: d.legal = 1'b0;
        endcase
      end
`ifdef RVMC_BRANCH_EN
      B_TYPE: begin
        if ((f3 == F3_BEQ) || (f3 == F3_BNE)) begin
          d.legal  = 1'b1;
          d.branch = 1'b1;
          d.br_ne  = (f3 == F3_BNE);
        end else begin
          d.legal = 1'b0;
        end
      end
`else
      B_TYPE: d.legal = 1'b0;
`endif
      default: d.legal = 1'b0;
    endcase
    if (!d.legal) d.wr = 1'b0;
    else d.wr = d.wr;
    return d;
  endfunction

endpackage

// File: rtl/rv_multicore_mc_alu.sv
// Combinational RV32I-subset ALU; shift amounts use only the low clog2(DSIZE) bits of b.
module rv_mc_alu
  import rv_multicore_mc_pkg::*;
#(
  parameter int DSIZE = 32
) (
  input  logic [DSIZE-1:0] a,
  input  logic [DSIZE-1:0] b,
  input  alu_op_e          alu_op,
  output logic [DSIZE-1:0] result
);

  localparam int SHW = (DSIZE > 1) ? $clog2(DSIZE) : 1;

  logic [SHW-1:0] w_shamt;
  logic           w_lt;
  logic           w_ltu;

  assign w_shamt = b[SHW-1:0];
  assign w_lt    = ($signed(a) < $signed(b));
  assign w_ltu   = (a < b);

  // Operation select.
  always_comb begin
    result = '0;
    case (alu_op)
      ALU_ADD:  result = a + b;
      ALU_SUB:  result = a - b;
      ALU_SLL:  result = a << w_shamt;
      ALU_SLT:  result = {{(DSIZE-1){1'b0}}, w_lt};
      ALU_SLTU: result = {{(DSIZE-1){1'b0}}, w_ltu};
      ALU_XOR:  result = a ^ b;
      ALU_SRL:  result = a >> w_shamt;
      ALU_SRA:  result = $signed(a) >>> w_shamt;
      ALU_OR:   result = a | b;
      ALU_AND:  result = a & b;
      default:  result = '0;
    endcase
  end

endmodule

// File: rtl/rv_multicore_mc.sv
// Multi-cycle RV32I-subset core: FETCH/DECODE/EXEC/WB sequencer, handshaked fetch, inline x0-hardwired regfile.
// Optional BEQ/BNE support is enabled by defining RVMC_BRANCH_EN.
module rv_multicore_mc
  import rv_multicore_mc_pkg::*;
#(
  parameter int               DSIZE    = 32,
  parameter int               ASIZE    = 5,
  parameter int               ISIZE    = 32,
  parameter logic [ISIZE-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst,
  output logic             imem_req,
  output logic [ISIZE-1:0] imem_addr,
  input  logic [ISIZE-1:0] imem_rdata,
  input  logic             imem_valid,
  output logic [ISIZE-1:0] instr_out,
  output logic [ISIZE-1:0] pc_out,
  output logic             retire_valid,
  output logic [ASIZE-1:0] retire_rd,
  output logic [DSIZE-1:0] retire_wdata,
  output logic             illegal
);

  localparam int NREGS = 2 ** ASIZE;

  state_e           r_state;
  logic [ISIZE-1:0] r_pc;
  logic [ISIZE-1:0] r_ir;
  logic [DSIZE-1:0] r_rf [NREGS];
  logic [DSIZE-1:0] r_op_a;
  logic [DSIZE-1:0] r_op_b;
  logic [DSIZE-1:0] r_result;
  dec_t             r_dec;
  logic             r_taken;
  logic             r_imem_req;
  logic             r_retire_valid;
  logic [ASIZE-1:0] r_retire_rd;
  logic [DSIZE-1:0] r_retire_wdata;
  logic             r_illegal;

  logic [ASIZE-1:0] w_rs1;
  logic [ASIZE-1:0] w_rs2;
  logic [ASIZE-1:0] w_rd;
  logic [DSIZE-1:0] w_rs1_val;
  logic [DSIZE-1:0] w_rs2_val;
  logic [DSIZE-1:0] w_imm;
  logic [ISIZE-1:0] w_br_off;
  logic [DSIZE-1:0] w_alu_result;
  logic             w_wr_en;
  dec_t             w_dec;

  // Register fields wider than ASIZE alias onto the low bits.
  assign w_rs1     = ASIZE'(r_ir[19:15]);
  assign w_rs2     = ASIZE'(r_ir[24:20]);
  assign w_rd      = ASIZE'(r_ir[11:7]);
  assign w_rs1_val = (w_rs1 == '0) ? '0 : r_rf[w_rs1];
  assign w_rs2_val = (w_rs2 == '0) ? '0 : r_rf[w_rs2];
  assign w_imm     = DSIZE'($signed(r_ir[31:20]));
  assign w_br_off  = ISIZE'($signed({r_ir[31], r_ir[7], r_ir[30:25], r_ir[11:8]}));
  assign w_dec     = decode_instr(r_ir[6:0], r_ir[14:12], r_ir[31:25]);
  assign w_wr_en   = r_dec.wr && (w_rd != '0);

  rv_mc_alu #(.DSIZE(DSIZE)) u_alu (
    .a      (r_op_a),
    .b      (r_op_b),
    .alu_op (r_dec.op),
    .result (w_alu_result)
  );

  // Sequencer, fetch handshake, operand/result latches and retire port.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state        <= FETCH;
      r_pc           <= RESET_PC;
      r_ir           <= '0;
      r_op_a         <= '0;
      r_op_b         <= '0;
      r_result       <= '0;
      r_dec          <= '{legal: 1'b0, wr: 1'b0, use_imm: 1'b0, branch: 1'b0, br_ne: 1'b0, op: ALU_ADD};
      r_taken        <= 1'b0;
      r_imem_req     <= 1'b0;
      r_retire_valid <= 1'b0;
      r_retire_rd    <= '0;
      r_retire_wdata <= '0;
      r_illegal      <= 1'b0;
    end else begin
      r_retire_valid <= 1'b0;
      r_illegal      <= 1'b0;
      case (r_state)
        FETCH: begin
          if (r_imem_req && imem_valid) begin
            r_ir       <= imem_rdata;
            r_imem_req <= 1'b0;
            r_state    <= DECODE;
          end else begin
            r_imem_req <= 1'b1;
          end
        end
        DECODE: begin
          r_op_a  <= w_rs1_val;
          r_op_b  <= w_dec.use_imm ? w_imm : w_rs2_val;
          r_dec   <= w_dec;
          r_state <= EXEC;
        end
        EXEC: begin
          r_result       <= w_alu_result;
          r_taken        <= r_dec.branch && ((r_op_a == r_op_b) != r_dec.br_ne);
          // Retire fields are registered here so they are visible during WB.
          r_retire_valid <= 1'b1;
          r_illegal      <= !r_dec.legal;
          r_retire_rd    <= w_wr_en ? w_rd : '0;
          r_retire_wdata <= w_wr_en ? w_alu_result : '0;
          r_state        <= WB;
        end
        WB: begin
          if (r_taken) r_pc <= r_pc + w_br_off;
          else r_pc <= r_pc + {{(ISIZE-1){1'b0}}, 1'b1};
          r_imem_req <= 1'b1;
          r_state    <= FETCH;
        end
        default: begin
          r_imem_req <= 1'b0;
          r_state    <= FETCH;
        end
      endcase
    end
  end

  // Register file write port; x0 is never written.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) r_rf[i] <= '0;
    end else if ((r_state == WB) && w_wr_en) begin
      r_rf[w_rd] <= r_result;
    end else begin
      r_rf[0] <= '0;
    end
  end

  assign imem_req     = r_imem_req;
  assign imem_addr    = r_pc;
  assign instr_out    = r_ir;
  assign pc_out       = r_pc;
  assign retire_valid = r_retire_valid;
  assign retire_rd    = r_retire_rd;
  assign retire_wdata = r_retire_wdata;
  assign illegal      = r_illegal;

endmodule

// File: tb/tb_rv_multicore_mc.sv
// Scoreboard bench for rv_multicore_mc: a directed program with hand-computed retire results.
module tb_rv_multicore_mc;

  localparam logic [31:0] SPUR = 32'h0630_0093;  // ADDI x1,x0,99 presented whenever req=0

  typedef struct {
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [31:0] wd;
    logic        ill;
    int          gap;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_valid;
  logic [31:0] instr_out;
  logic [31:0] pc_out;
  logic        retire_valid;
  logic [4:0]  retire_rd;
  logic [31:0] retire_wdata;
  logic        illegal;

  logic [31:0] imem [32];
  exp_t        sb_q [$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;

  rv_multicore_mc dut (
    .clk          (clk),
    .rst          (rst),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_rdata   (imem_rdata),
    .imem_valid   (imem_valid),
    .instr_out    (instr_out),
    .pc_out       (pc_out),
    .retire_valid (retire_valid),
    .retire_rd    (retire_rd),
    .retire_wdata (retire_wdata),
    .illegal      (illegal)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [31:0] pc, input logic [4:0] rd, input logic [31:0] wd,
                      input logic ill, input int gap);
    exp_t e;
    e.pc = pc; e.rd = rd; e.wd = wd; e.ill = ill; e.gap = gap;
    sb_q.push_back(e);
  endtask

  function automatic int wait_of(input logic [31:0] a);
    if (a == 32'd7) return 3;
    else if (a == 32'd22) return 6;
    else return 0;
  endfunction

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (sb_q.size() != 0) begin
      errors++;
      checks++;
      $display("FAIL drain_timeout: %0d entries left, required 0", sb_q.size());
    end
  endtask

  // Instruction memory with per-address wait states; drives garbage with valid=1 when req=0.
  initial begin
    int cnt;
    cnt = 0;
    imem_valid = 1'b0;
    imem_rdata = SPUR;
    forever begin
      @(negedge clk);
      if (!rst || !imem_req) begin
        cnt = 0;
        imem_valid = 1'b1;
        imem_rdata = SPUR;
      end else if (cnt >= wait_of(imem_addr)) begin
        imem_valid = 1'b1;
        imem_rdata = imem[imem_addr[4:0]];
      end else begin
        imem_valid = 1'b0;
        imem_rdata = SPUR;
        cnt++;
      end
    end
  end

  // Monitor: fetch handshake stability and scoreboard compare on every retire.
  initial begin
    int          last;
    logic        pr;
    logic        pv;
    logic [31:0] pa;
    exp_t        e;
    last = 0; pr = 1'b0; pv = 1'b0; pa = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        pr = 1'b0;
        continue;
      end
      if (pr && !pv) begin
        chk("req_hold", 32'(imem_req), 32'd1);
        chk("addr_hold", imem_addr, pa);
      end
      if (pr && pv) chk("req_drop", 32'(imem_req), 32'd0);
      pr = imem_req; pv = imem_valid; pa = imem_addr;
      if (retire_valid) begin
        if (sb_q.size() == 0) begin
          errors++;
          checks++;
          $display("FAIL unexpected_retire: pc %h rd %0d, required no retire", pc_out, retire_rd);
        end else begin
          e = sb_q.pop_front();
          chk("retire_pc", pc_out, e.pc);
          chk("retire_rd", 32'(retire_rd), 32'(e.rd));
          chk("retire_wdata", retire_wdata, e.wd);
          chk("illegal", 32'(illegal), 32'(e.ill));
          if (e.gap != 0) chk("cpi", 32'(cyc - last), 32'(e.gap));
        end
        last = cyc;
      end
    end
  end

  // Stimulus: program load, expected pushes, reset scenarios.
  initial begin
    int c0;
    int n;
    rst = 1'b0;
    for (int i = 0; i < 32; i++) imem[i] = 32'h0000_0000;
    imem[0]  = 32'h0050_0093;  // ADDI x1,x0,5
    imem[1]  = 32'hFFF0_0093;  // ADDI x1,x0,-1
    imem[2]  = 32'h01C0_D113;  // SRLI x2,x1,28
    imem[3]  = 32'h41C0_D193;  // SRAI x3,x1,28
    imem[4]  = 32'h0010_3233;  // SLTU x4,x0,x1
    imem[5]  = 32'h0010_22B3;  // SLT  x5,x0,x1
    imem[6]  = 32'h0070_0013;  // ADDI x0,x0,7
    imem[7]  = 32'h0030_0113;  // ADDI x2,x0,3   (3 wait states)
    imem[8]  = 32'h0000_0000;  // illegal opcode
    imem[9]  = 32'h0030_0093;  // ADDI x1,x0,3
    imem[10] = 32'h0020_8463;  // BEQ x1,x2,+8
    imem[11] = 32'h0020_E3B3;  // OR   x7,x1,x2
    imem[12] = 32'h0020_F433;  // AND  x8,x1,x2
    imem[13] = 32'h00F0_C493;  // XORI x9,x1,15
    imem[14] = 32'h0020_9463;  // BNE x1,x2,+8
    imem[15] = 32'h4010_0533;  // SUB  x10,x0,x1
    imem[16] = 32'h0010_95B3;  // SLL  x11,x1,x1
    imem[17] = 32'hFFE5_2613;  // SLTI x12,x10,-2
    imem[18] = 32'hFFF0_B693;  // SLTIU x13,x1,-1
    imem[19] = 32'h4015_5733;  // SRA  x14,x10,x1
    imem[20] = 32'h0F05_7793;  // ANDI x15,x10,0xF0
    imem[21] = 32'h0200_0833;  // funct7=0000001 -> illegal
    imem[22] = 32'h0010_0913;  // ADDI x18,x0,1 (6 wait states, cut by reset)

    push(32'd0, 5'd1, 32'd5, 1'b0, 0);
    push(32'd1, 5'd1, 32'hFFFF_FFFF, 1'b0, 4);
    push(32'd2, 5'd2, 32'h0000_000F, 1'b0, 4);
    push(32'd3, 5'd3, 32'hFFFF_FFFF, 1'b0, 4);
    push(32'd4, 5'd4, 32'd1, 1'b0, 4);
    push(32'd5, 5'd5, 32'd0, 1'b0, 4);
    push(32'd6, 5'd0, 32'd0, 1'b0, 4);
    push(32'd7, 5'd2, 32'd3, 1'b0, 7);
    push(32'd8, 5'd0, 32'd0, 1'b1, 4);
    push(32'd9, 5'd1, 32'd3, 1'b0, 4);
`ifdef RVMC_BRANCH_EN
    push(32'd10, 5'd0, 32'd0, 1'b0, 4);
    push(32'd14, 5'd0, 32'd0, 1'b0, 4);
`else
    push(32'd10, 5'd0, 32'd0, 1'b1, 4);
    push(32'd11, 5'd7, 32'd3, 1'b0, 4);
    push(32'd12, 5'd8, 32'd3, 1'b0, 4);
    push(32'd13, 5'd9, 32'd12, 1'b0, 4);
    push(32'd14, 5'd0, 32'd0, 1'b1, 4);
`endif
    push(32'd15, 5'd10, 32'hFFFF_FFFD, 1'b0, 4);
    push(32'd16, 5'd11, 32'd24, 1'b0, 4);
    push(32'd17, 5'd12, 32'd1, 1'b0, 4);
    push(32'd18, 5'd13, 32'd1, 1'b0, 4);
    push(32'd19, 5'd14, 32'hFFFF_FFFF, 1'b0, 4);
    push(32'd20, 5'd15, 32'h0000_00F0, 1'b0, 4);
    push(32'd21, 5'd0, 32'd0, 1'b1, 4);

    #1;
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_pc", pc_out, 32'd0);
    chk("rst_ir", instr_out, 32'd0);
    chk("rst_retire", 32'(retire_valid), 32'd0);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;

    // First fetch latency: retire 3 cycles after req rises, pc=1 one cycle later.
    n = 0;
    do begin @(negedge clk); n++; end while (!imem_req && n < 20);
    chk("first_req", 32'(imem_req), 32'd1);
    c0 = cyc;
    n = 0;
    do begin @(negedge clk); n++; end while (!retire_valid && n < 20);
    chk("first_retire_cycle", 32'(cyc - c0), 32'd3);
    @(negedge clk);
    chk("pc_after_first", pc_out, 32'd1);
    chk("hold_rd", 32'(retire_rd), 32'd1);
    chk("hold_wdata", retire_wdata, 32'd5);
    chk("pulse_low", 32'(retire_valid), 32'd0);

    drain(400);

    // Reset during a fetch wait; the abandoned and spurious responses must not retire.
    n = 0;
    do begin @(negedge clk); n++; end while (!(imem_req && imem_addr == 32'd22) && n < 40);
    chk("wait_fetch_addr", imem_addr, 32'd22);
    repeat (2) @(negedge clk);
    #3 rst = 1'b0;
    #1;
    chk("midreset_req", 32'(imem_req), 32'd0);
    chk("midreset_pc", pc_out, 32'd0);
    chk("midreset_ir", instr_out, 32'd0);
    push(32'd0, 5'd1, 32'd5, 1'b0, 0);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!imem_req && n < 20);
    chk("restart_addr", imem_addr, 32'd0);
    drain(100);
    chk("restart_ir", instr_out, 32'h0050_0093);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rv_multicore_mc.md
Name: rv_multicore_mc

Overview:
- Parametrised multi-cycle RV32I-subset core. Successor to the single-cycle fetch/regfile/ALU top.
- Adds an FSM sequencer, a variable-latency instruction-memory handshake, I-type immediates and an x0-hardwired register file.
- Width and register count are parametrised.
- Exposes a retire port for the verification scoreboard.

Parameters:
- DSIZE, 32, datapath and register width in bits (min 8).
- ASIZE, 5, register address width; NREGS = 2**ASIZE.
- ISIZE, 32, instruction and PC width.
- RESET_PC, 0, PC value loaded on reset (word address).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- imem_req  out  1  fetch request; held until accepted.
- imem_addr  out  ISIZE  word address, equals pc while imem_req=1.
- imem_rdata  in  ISIZE  instruction word; sampled when imem_req && imem_valid.
- imem_valid  in  1  fetch data valid; ignored when imem_req=0.
- instr_out  out  ISIZE  current instruction register (IR).
- pc_out  out  ISIZE  current PC.
- retire_valid  out  1  one-cycle pulse per completed instruction.
- retire_rd  out  ASIZE  destination register of the retiring instruction (0 if no write).
- retire_wdata  out  DSIZE  value written; 0 if no write.
- illegal  out  1  pulses together with retire_valid for an unsupported encoding.

Behaviour:
- Reset (rst=0, async):
  - state=FETCH, pc=RESET_PC, IR=0, all registers 0.
  - imem_req, retire_valid, illegal, retire_rd, retire_wdata all 0.
  - Reset mid-fetch drops imem_req immediately; any in-flight response is discarded.
- FSM states and transitions:
  - FETCH: imem_req=1, imem_addr=pc. On imem_valid (same cycle allowed), IR<=imem_rdata, go to DECODE. Otherwise stay.
  - DECODE: read rs1 = IR[19:15] and rs2 = IR[24:20]; both latched into operand regs. Compute imm = sign-extend(IR[31:20]) to DSIZE. Classify opcode. Go to EXEC.
  - EXEC: ALU result latched. Go to WB.
  - WB: write rd = IR[11:7] if legal, write-type and rd!=0. Pulse retire_valid. pc<=pc+1, wrapping at 2**ISIZE. Go to FETCH.
- Timing:
  - CPI = 4 + imem wait cycles; 4 with a zero-wait memory.
  - imem_req deasserts the cycle after acceptance.
- Register indexing: register indices above NREGS-1 use the low ASIZE bits. x0 always reads 0 and writes to it are dropped.
- R_TYPE (0110011), selected by funct3/funct7[5]:
  - ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND.
- I_TYPE (0010011):
  - ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI.
  - Shift amount is imm[4:0].
- Arithmetic rules:
  - Modulo 2**DSIZE, no overflow flag.
  - Shift amount is masked to clog2(DSIZE) bits.
  - SLT/SLTI are signed, SLTU/SLTIU unsigned; result 1 or 0 zero-extended.
- Illegal encodings (any other opcode or funct combination):
  - No register write; retire_rd=0, retire_wdata=0.
  - illegal=1 with retire_valid; pc still increments.
- Retire port: retire_rd and retire_wdata hold their value until the next retire.

Optional Feature:
- Macro: RVMC_BRANCH_EN.
- When defined:
  - Opcode 1100011, funct3 000 = BEQ, 001 = BNE. Comparison is done in EXEC.
  - Taken: pc <= pc + sext({IR[31],IR[7],IR[30:25],IR[11:8]}) in word units. Not taken: pc+1.
  - Branches retire with retire_rd=0; other funct3 values are illegal.
- When undefined: opcode 1100011 is illegal.

Decomposition:
- Shared define file:
  - opcode constants R_TYPE, I_TYPE, B_TYPE.
  - funct3/funct7 codes.
  - ALU op encoding.
  - FSM state encoding (FETCH=0, DECODE=1, EXEC=2, WB=3).
- One sub-module: rv_mc_alu, combinational, parameter DSIZE, inputs a, b, alu_op; output result.
- Register file stays inline.

Test Plan:
- Reset then zero-wait memory supplying ADDI x1,x0,5: imem_req high at cycle 0; retire at cycle 3 with rd=1, wdata=5; pc=1 at cycle 4.
- ADDI x1,x0,-1 then SRLI x2,x1,28 then SRAI x3,x1,28 → x2=0x0000000F, x3=0xFFFFFFFF; SLTU x4,x0,x1 → 1; SLT x5,x0,x1 → 0.
- imem_valid delayed 3 cycles → imem_req and imem_addr stable throughout the wait, single retire, CPI=7. imem_valid pulses with req=0 → ignored.
- ADDI x0,x0,7 → retire_rd=0, x0 reads 0. Opcode 0000000 → illegal=1, no write, pc+1.
- rst asserted during FETCH wait → imem_req=0 asynchronously. After release, first fetch address is RESET_PC and the late imem_valid is discarded.
- RVMC_BRANCH_EN: x1=x2=3, BEQ offset +8 at pc=10 → next imem_addr=14. BNE same operands → 11. Without the macro → illegal pulse, pc=11.
